// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioning path.
package btn_pkg;

  typedef enum logic [1:0] {
    RP_IDLE   = 2'd0,
    RP_DELAY  = 2'd1,
    RP_REPEAT = 2'd2
  } rep_state_t;

  // Defaults assume a 50 MHz board clock.
  localparam int unsigned BTN_DB_CYCLES     = 500000;
  localparam int unsigned BTN_REPEAT_DELAY  = 25000000;
  localparam int unsigned BTN_REPEAT_PERIOD = 5500000;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, counting debouncer and auto-repeat FSM.
// Emits a one-cycle ev on press and on every auto-repeat while held.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = BTN_DB_CYCLES,
  parameter int unsigned REPEAT_DELAY  = BTN_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = BTN_REPEAT_PERIOD,
  parameter int unsigned CNT_W         = 26
) (
  input  logic CLK,
  input  logic clear,
  input  logic btn,
  output logic db,
  output logic ev
);

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] rep_cnt;
  rep_state_t       state, next_state;
  logic             rep_expire;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (clear) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db     <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 != db) begin
        if (db_cnt == DB_LAST) begin
          db     <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign rep_expire = ((state == RP_DELAY)  && (rep_cnt == DELAY_LAST)) ||
                      ((state == RP_REPEAT) && (rep_cnt == PERIOD_LAST));

  // Counter restarts on entry to RP_DELAY, on every expiry and whenever released.
  always_ff @(posedge CLK) begin
    if (clear) begin
      state   <= RP_IDLE;
      rep_cnt <= '0;
    end else begin
      state <= next_state;
      if ((state == RP_IDLE) || !db || rep_expire) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  // NOTE: default assignment first keeps combinational processes free of latches.
  always_comb begin
    next_state = state;
    case (state)
      RP_IDLE:   if (db) next_state = RP_DELAY;
      RP_DELAY:  if (!db) next_state = RP_IDLE;
                 else if (rep_expire) next_state = RP_REPEAT;
      RP_REPEAT: if (!db) next_state = RP_IDLE;
      default:   next_state = RP_IDLE;
    endcase
  end

  // db low suppresses ev, so a release beats a same-cycle expiry.
  always_comb begin
    ev = 1'b0;
    case (state)
      RP_IDLE:             ev = db;
      RP_DELAY, RP_REPEAT: ev = db && rep_expire;
      default:             ev = 1'b0;
    endcase
  end

endmodule

// File: rtl/btn_conditioner.sv
// Left/Right button conditioning: two channels feeding move-request latches that
// hold until the game's mv_tick, with last-press-wins direction arbitration.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = BTN_DB_CYCLES,
  parameter int unsigned REPEAT_DELAY  = BTN_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = BTN_REPEAT_PERIOD,
  parameter int unsigned CNT_W         = 26
) (
  input  logic CLK,
  input  logic clear,
  input  logic Left,
  input  logic Right,
  input  logic mv_tick,
  output logic left_req,
  output logic right_req,
  output logic left_db,
  output logic right_db
);

  logic left_ev, right_ev;

  btn_channel #(
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CNT_W        (CNT_W)
  ) u_left (
    .CLK  (CLK),
    .clear(clear),
    .btn  (Left),
    .db   (left_db),
    .ev   (left_ev)
  );

  btn_channel #(
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CNT_W        (CNT_W)
  ) u_right (
    .CLK  (CLK),
    .clear(clear),
    .btn  (Right),
    .db   (right_db),
    .ev   (right_ev)
  );

  // Fresh events outrank mv_tick; simultaneous opposite events cancel out.
  always_ff @(posedge CLK) begin
    if (clear) begin
      left_req  <= 1'b0;
      right_req <= 1'b0;
    end else if (left_ev && right_ev) begin
      left_req  <= 1'b0;
      right_req <= 1'b0;
    end else if (left_ev) begin
      left_req  <= 1'b1;
      right_req <= 1'b0;
    end else if (right_ev) begin
      left_req  <= 1'b0;
      right_req <= 1'b1;
    end else if (mv_tick) begin
      left_req  <= 1'b0;
      right_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random button/tick/clear traffic,
// checked every cycle against a behavioural model built from held-time arithmetic.
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic CLK = 1'b0;
  logic clear, Left, Right, mv_tick;
  logic left_req, right_req, left_db, right_db;

  always #5 CLK = ~CLK;

  btn_conditioner #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .CNT_W        (26)
  ) dut (
    .CLK      (CLK),
    .clear    (clear),
    .Left     (Left),
    .Right    (Right),
    .mv_tick  (mv_tick),
    .left_req (left_req),
    .right_req(right_req),
    .left_db  (left_db),
    .right_db (right_db)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model, index 0 = Left, 1 = Right.
  // raw_d1/raw_d2 are the raw level one and two edges back; run counts
  // consecutive disagreeing cycles; held counts cycles since the accepted press.
  bit m_raw_d1 [2];
  bit m_raw_d2 [2];
  bit m_db     [2];
  int m_run    [2];
  int m_held   [2];
  bit m_req    [2];

  function automatic bit model_ev(input int i);
    if (!m_db[i]) return 1'b0;
    return (m_held[i] == 0) || (m_held[i] == RD) ||
           ((m_held[i] > RD) && ((m_held[i] - RD) % RP == 0));
  endfunction

  task automatic model_edge();
    bit ev [2];
    bit raw [2];
    raw[0] = Left;
    raw[1] = Right;
    if (clear) begin
      for (int i = 0; i < 2; i++) begin
        m_raw_d1[i] = 0; m_raw_d2[i] = 0; m_db[i] = 0;
        m_run[i] = 0; m_held[i] = 0; m_req[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 2; i++) ev[i] = model_ev(i);
    if (ev[0] && ev[1]) begin m_req[0] = 0; m_req[1] = 0; end
    else if (ev[0])     begin m_req[0] = 1; m_req[1] = 0; end
    else if (ev[1])     begin m_req[0] = 0; m_req[1] = 1; end
    else if (mv_tick)   begin m_req[0] = 0; m_req[1] = 0; end
    for (int i = 0; i < 2; i++) begin
      if (m_db[i]) m_held[i]++;
      if (m_raw_d2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_db[i]   = m_raw_d2[i];
          m_run[i]  = 0;
          m_held[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_raw_d2[i] = m_raw_d1[i];
      m_raw_d1[i] = raw[i];
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check("left_db",   left_db,   m_db[0]);
    check("right_db",  right_db,  m_db[1]);
    check("left_req",  left_req,  m_req[0]);
    check("right_req", right_req, m_req[1]);
    check("req_excl",  left_req & right_req, 1'b0);
  endtask

  task automatic restart();
    clear = 1'b1; Left = 1'b0; Right = 1'b0; mv_tick = 1'b0;
    step();
    clear = 1'b0;
  endtask

  int rises[$];
  int exp_rises[6] = '{7, 27, 35, 43, 51, 59};
  bit prev;
  bit lvl [2];
  int hold [2];

  initial begin
    clear = 1'b1; Left = 1'b0; Right = 1'b0; mv_tick = 1'b0;
    step();
    step();
    check("rst_left_req",  left_req,  1'b0);
    check("rst_right_req", right_req, 1'b0);
    check("rst_left_db",   left_db,   1'b0);
    check("rst_right_db",  right_db,  1'b0);
    clear = 1'b0;

    // Bounce shorter than the debounce window never registers.
    for (int k = 0; k < 30; k++) begin
      Left = ((k / 2) % 2) != 0;
      step();
      check("bounce_db",  left_db,  1'b0);
      check("bounce_req", left_req, 1'b0);
    end

    // Clean press, consumed by mv_tick.
    restart();
    Left = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      mv_tick = (k == 16);
      step();
      if (k == 5)  check("press_db_early", left_db, 1'b0);
      if (k == 6)  check("press_db_edge",  left_db, 1'b1);
      if (k == 6)  check("press_req_early", left_req, 1'b0);
      if (k == 7)  check("press_req_edge", left_req, 1'b1);
      if (k == 15) check("press_req_hold", left_req, 1'b1);
      if (k == 16) check("press_req_consumed", left_req, 1'b0);
    end
    mv_tick = 1'b0;

    // Auto-repeat with tick acknowledging each request; release races an expiry.
    restart();
    rises.delete();
    prev = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      Right = (k <= 60);
      step();
      if (right_req && !prev) rises.push_back(k);
      mv_tick = right_req;
      prev = right_req;
    end
    mv_tick = 1'b0;
    check("repeat_count", rises.size(), 6);
    for (int i = 0; i < rises.size() && i < 6; i++) check("repeat_edge", rises[i], exp_rises[i]);

    // Event coincident with mv_tick survives.
    restart();
    Left = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      mv_tick = (k == 7);
      step();
    end
    mv_tick = 1'b0;
    check("ev_tick_keep", left_req, 1'b1);

    // Left press takes over a pending right request.
    restart();
    Right = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    check("takeover_right_first", right_req, 1'b1);
    Left = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) check("takeover_right_before", right_req, 1'b1);
      if (k == 7) check("takeover_left",  left_req,  1'b1);
      if (k == 7) check("takeover_right", right_req, 1'b0);
    end

    // Simultaneous presses cancel.
    restart();
    Left = 1'b1; Right = 1'b1;
    for (int k = 1; k <= 12; k++) step();
    check("both_left_db",  left_db,   1'b1);
    check("both_right_db", right_db,  1'b1);
    check("both_left_req", left_req,  1'b0);
    check("both_right_req", right_req, 1'b0);

    // Clear in the middle of RP_DELAY forces a fresh debounce and press.
    restart();
    Left = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      clear = (k == 26);
      step();
      if (k == 25) check("midrst_req_before", left_req, 1'b1);
      if (k == 26) check("midrst_req_cleared", left_req, 1'b0);
      if (k == 26) check("midrst_db_cleared", left_db, 1'b0);
      if (k == 32) check("midrst_req_early", left_req, 1'b0);
      if (k == 33) check("midrst_req_again", left_req, 1'b1);
    end
    clear = 1'b0;

    // Random traffic: long holds mixed with short bounces, random ticks and clears.
    restart();
    for (int i = 0; i < 2; i++) begin lvl[i] = 1'b0; hold[i] = 0; end
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i] == 0) begin
          lvl[i]  = !lvl[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                 : int'($urandom_range(5, 60));
        end
        hold[i]--;
      end
      Left    = lvl[0];
      Right   = lvl[1];
      mv_tick = ($urandom_range(0, 5) == 0);
      clear   = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input conditioning stage directly upstream of the falling-object game core. Turns the raw Left/Right push-buttons into clean, single-shot move requests. Each request is held until the game's move tick consumes it, so a press shorter than one move period is never lost and a held button auto-repeats at a controlled rate. Runs on the board clock; the game core samples `left_req`/`right_req` in place of the raw buttons.

## Interface
Parameters:
- `DB_CYCLES`, 500000: consecutive CLK cycles of stable input required to accept a level change (10 ms at 50 MHz); ≥2.
- `REPEAT_DELAY`, 25000000: cycles a button must stay held after acceptance before the first auto-repeat; ≥2.
- `REPEAT_PERIOD`, 5500000: cycles between subsequent auto-repeats, matching the move tick; ≥2.
- `CNT_W`, 26: width of all internal counters; must hold max(parameters)−1.

Ports:
- `CLK` in 1: board clock; the only clock.
- `clear` in 1: reset, synchronous, active-high.
- `Left` in 1: raw left button, asynchronous, active-high.
- `Right` in 1: raw right button, asynchronous, active-high.
- `mv_tick` in 1: single-CLK pulse, in the CLK domain, marking the game core's move-sample point; acts as the consume acknowledge.
- `left_req` out 1: pending left move request.
- `right_req` out 1: pending right move request.
- `left_db` out 1: debounced left level.
- `right_db` out 1: debounced right level.

## Operation
- Per channel: 2-FF synchronizer (`s1`, `s2`), then debouncer, then repeat FSM, then request latch.
- Debouncer:
  - While `s2 != db`, the counter increments.
  - When the counter is `DB_CYCLES-1` and `s2 != db` still holds, `db` takes the value of `s2` and the counter clears.
  - Any cycle with `s2 == db` clears the counter. Glitches shorter than `DB_CYCLES` are ignored.
- Press event: `db` 0→1.
- Repeat FSM states: RP_IDLE, RP_DELAY, RP_REPEAT.
  - RP_IDLE: a press event emits one `ev` and goes to RP_DELAY, counter cleared.
  - RP_DELAY: `db`=0 returns to RP_IDLE. Counter reaching `REPEAT_DELAY-1` emits `ev` and goes to RP_REPEAT, counter cleared.
  - RP_REPEAT: `db`=0 returns to RP_IDLE. Counter reaching `REPEAT_PERIOD-1` emits `ev`, counter cleared.
  - Release always wins over a same-cycle expiry: no `ev` is emitted.
- Request latch:
  - `ev` on a channel sets that channel's `req`.
  - `mv_tick` clears both `req`s.
  - `ev` and `mv_tick` in the same cycle: `req` is set (the new event survives).
- Direction arbitration (last press wins):
  - `ev` on one channel clears the other channel's `req` in the same cycle.
  - `ev` on both channels in the same cycle clears both `req`s and sets neither.
  - `left_req` and `right_req` are therefore never both 1.
- Requests do not accumulate: multiple `ev`s before `mv_tick` yield one request.
- `clear` (at any time, including mid-debounce or mid-repeat):
  - next edge: `s1`, `s2`, `db`, all counters and all `req`s go to 0; FSMs go to RP_IDLE.
  - A button held through `clear` must re-debounce from 0 and produces a fresh press event.

## Timing
- Reset values: `left_req`=0, `right_req`=0, `left_db`=0, `right_db`=0.
- Raw rise at edge 0, stable: `db` rises at edge `DB_CYCLES+2`; `req` rises at edge `DB_CYCLES+3`.
- Release latency to `db` falling is the same as press latency to `db` rising.
- First repeat `ev`: `REPEAT_DELAY` edges after press `ev`. Subsequent repeats: every `REPEAT_PERIOD` edges.
- `req` is registered; it falls the edge after `mv_tick` is sampled.
- All outputs are registered: no combinational path from inputs to outputs.

## Structure
- Shared package `btn_pkg`:
  - `rep_state_t` enum {RP_IDLE, RP_DELAY, RP_REPEAT}.
  - Default constants `BTN_DB_CYCLES`, `BTN_REPEAT_DELAY`, `BTN_REPEAT_PERIOD`.
- Sub-module `btn_channel` (synchronizer + debouncer + repeat FSM), outputs `db` and a one-cycle `ev`. Instantiated twice.
- Top level holds the request latches and the arbitration.

## Test plan
Bench parameters: `DB_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.

- Reset/bounce: `clear` for 2 edges → all outputs 0. Then `Left` toggles every 2 cycles for 30 cycles → `left_db`=0 and `left_req`=0 throughout.
- Clean press: `Left` held from edge 0 → `left_db`=1 at edge 6, `left_req`=1 at edge 7. `left_req` holds until `mv_tick` at edge 15 → 0 at edge 16.
- Auto-repeat: `Right` held 60 cycles with `mv_tick` pulsed after each `right_req` rise → `right_req` rises at edges 7, 27, 35, 43, 51, 59. `Right` released at edge 60 → no further rise.
- Collisions:
  - `ev` coincident with `mv_tick` → `req` stays 1.
  - Left press while `right_req`=1 → `right_req`=0 and `left_req`=1 on the same edge.
  - Both raw inputs rising together → neither `req` set.
- Mid-operation reset: `clear` asserted for 1 cycle at edge 25 of a held `Left` (RP_DELAY) → outputs 0 at edge 26. With `Left` still high, `left_req` rises again at edge 33.
